// File: rtl/codma_task_ctrl.sv
// Descriptor sequencer for the codma copy engine: fetches two-word descriptors,
// validates bounds, issues 8-byte/32-byte copy commands, follows links, writes status.
module codma_task_ctrl #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned MAX_CHAIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] task_pointer,
  input  logic [31:0] status_pointer,
  output logic        busy,
  output logic        irq,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_burst,
  output logic [31:0] cmd_src,
  output logic [31:0] cmd_dst,
  input  logic        cmd_done
);

  localparam int unsigned CW = $clog2(MAX_CHAIN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_WAIT0, S_RD1, S_WAIT1, S_CHECK,
    S_ISSUE, S_WAITDONE, S_LINK, S_WRSTAT, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [31:0]   ptr, ptr_n;
  logic [31:0]   sptr, sptr_n;
  logic [31:0]   typ, typ_n;
  logic [31:0]   src, src_n;
  logic [31:0]   dst, dst_n;
  logic [31:0]   len, len_n;
  logic [2:0]    status, status_n;
  logic [CW-1:0] chain, chain_n;

  logic [31:0] unit;
  logic        misaligned;
  logic [32:0] src_end;
  logic [32:0] dst_end;

  assign unit       = (typ == 32'd0) ? 32'd8 : 32'd32;
  assign misaligned = (typ == 32'd0) ? (len[2:0] != 3'd0) : (len[4:0] != 5'd0);
  assign src_end    = {1'b0, src} + {1'b0, len};
  assign dst_end    = {1'b0, dst} + {1'b0, len};

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    sptr_n   = sptr;
    typ_n    = typ;
    src_n    = src;
    dst_n    = dst;
    len_n    = len;
    status_n = status;
    chain_n  = chain;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_RD0;
          ptr_n    = task_pointer;
          sptr_n   = status_pointer;
          status_n = 3'd0;
          chain_n  = CW'(1);
        end
      end
      S_RD0:   if (mem_gnt) state_n = S_WAIT0;
      S_WAIT0: begin
        if (mem_rvalid) begin
          typ_n   = mem_rdata[31:0];
          src_n   = mem_rdata[63:32];
          state_n = S_RD1;
        end
      end
      S_RD1:   if (mem_gnt) state_n = S_WAIT1;
      S_WAIT1: begin
        if (mem_rvalid) begin
          dst_n   = mem_rdata[31:0];
          len_n   = mem_rdata[63:32];
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (typ > 32'd2) begin
          status_n = 3'd3;
          state_n  = S_WRSTAT;
        end else if (misaligned) begin
          status_n = 3'd2;
          state_n  = S_WRSTAT;
        end else if (src_end > 33'(MEM_BYTES) || dst_end > 33'(MEM_BYTES)) begin
          status_n = 3'd1;
          state_n  = S_WRSTAT;
        end else if (len == 32'd0) begin
          status_n = 3'd0;
          state_n  = S_WRSTAT;
        end else begin
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: if (cmd_ready) state_n = S_WAITDONE;
      // cmd_done is only sampled here, so a pulse coincident with cmd_ready is dropped
      S_WAITDONE: begin
        if (cmd_done) begin
          src_n = src + unit;
          dst_n = dst + unit;
          len_n = len - unit;
          if (len != unit)          state_n = S_ISSUE;
          else if (typ == 32'd2)    state_n = S_LINK;
          else                      state_n = S_WRSTAT;
        end
      end
      S_LINK: begin
        if (chain == CW'(MAX_CHAIN)) begin
          status_n = 3'd1;
          state_n  = S_WRSTAT;
        end else begin
          ptr_n   = ptr + 32'd32;
          chain_n = chain + CW'(1);
          state_n = S_RD0;
        end
      end
      S_WRSTAT: if (mem_gnt) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      ptr    <= '0;
      sptr   <= '0;
      typ    <= '0;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      status <= '0;
      chain  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      sptr   <= sptr_n;
      typ    <= typ_n;
      src    <= src_n;
      dst    <= dst_n;
      len    <= len_n;
      status <= status_n;
      chain  <= chain_n;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      irq       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_valid <= 1'b0;
      cmd_burst <= 1'b0;
      cmd_src   <= '0;
      cmd_dst   <= '0;
    end else begin
      busy      <= (state_n != S_IDLE);
      irq       <= (state_n == S_DONE);
      mem_req   <= (state_n == S_RD0) || (state_n == S_RD1) || (state_n == S_WRSTAT);
      mem_we    <= (state_n == S_WRSTAT);
      cmd_valid <= (state_n == S_ISSUE);
      cmd_src   <= src_n;
      cmd_dst   <= dst_n;
      if (state_n == S_ISSUE) cmd_burst <= (typ_n != 32'd0);
      case (state_n)
        S_RD0:    mem_addr <= ptr_n;
        S_RD1:    mem_addr <= ptr_n + 32'd8;
        S_WRSTAT: begin
          mem_addr  <= sptr_n;
          mem_wdata <= {61'b0, status_n};
        end
        default:  mem_addr <= mem_addr;
      endcase
    end
  end

endmodule

// File: tb/tb_codma_task_ctrl.sv
// Self-checking bench for codma_task_ctrl: directed and random descriptor chains
// compared against a descriptor-walking reference model.
module tb_codma_task_ctrl;

  localparam int unsigned MAXC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] task_pointer;
  logic [31:0] status_pointer;
  logic        busy;
  logic        irq;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_burst;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic        cmd_done = 1'b0;

  codma_task_ctrl #(.MEM_BYTES(256), .MAX_CHAIN(MAXC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .task_pointer(task_pointer), .status_pointer(status_pointer),
    .busy(busy), .irq(irq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_burst(cmd_burst),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  bit fast_mode = 0;
  bit stall_mode = 0;
  bit long_done = 0;
  bit gnt_hold = 0;

  logic [63:0] mem [32];
  logic [64:0] exp_cmd[$], act_cmd[$];
  logic [31:0] exp_rd[$], act_rd[$], act_wa[$];
  logic [63:0] act_wd[$];
  logic [2:0]  exp_status;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    logic [4:0] i;
    i = a[7:3];
    return mem[i];
  endfunction

  task automatic put_desc(input logic [31:0] a, input logic [31:0] t, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l);
    logic [4:0] i;
    i = a[7:3];
    mem[i] = {s, t};
    i = i + 5'd1;
    mem[i] = {l, d};
  endtask

  // Walks the descriptor chain in memory and lists the commands, reads and status expected
  task automatic model(input logic [31:0] tp);
    logic [31:0] p;
    logic [63:0] w0, w1;
    longint unsigned s, d, l, u, t;
    exp_cmd.delete();
    exp_rd.delete();
    exp_status = 3'd0;
    p = tp;
    for (int n = 1; n <= 16; n++) begin
      if (n > int'(MAXC)) begin exp_status = 3'd1; break; end
      w0 = mem_rd(p);
      w1 = mem_rd(p + 32'd8);
      exp_rd.push_back(p);
      exp_rd.push_back(p + 32'd8);
      t = w0[31:0]; s = w0[63:32]; d = w1[31:0]; l = w1[63:32];
      if (t > 2) begin exp_status = 3'd3; break; end
      u = (t == 0) ? 8 : 32;
      if (l % u != 0) begin exp_status = 3'd2; break; end
      if (s + l > 256 || d + l > 256) begin exp_status = 3'd1; break; end
      for (longint unsigned o = 0; o < l; o += u)
        exp_cmd.push_back({(t != 0), 32'(s + o), 32'(d + o)});
      if (t != 2 || l == 0) break;
      p = p + 32'd32;
    end
  endtask

  // Memory port: random grant delay, read data 1..3 cycles after grant, stray rvalids
  initial begin
    bit pend;
    bit gw;
    int w;
    logic [31:0] ga, ra;
    logic [63:0] gd;
    pend = 0; w = 0; gw = 0; ga = '0; ra = '0; gd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_gnt = 0; mem_rvalid = 0; pend = 0;
      end else begin
        if (mem_gnt) begin
          if (gw) begin
            act_wa.push_back(ga);
            act_wd.push_back(gd);
          end else begin
            act_rd.push_back(ga);
            pend = 1; ra = ga;
            w = fast_mode ? 0 : $urandom_range(0, 2);
          end
        end
        mem_gnt = 0;
        mem_rvalid = 0;
        mem_rdata = {$urandom, $urandom};
        if (pend) begin
          if (w == 0) begin
            mem_rvalid = 1; mem_rdata = mem_rd(ra); pend = 0;
          end else w--;
        end else if (mem_req && !gnt_hold && (fast_mode || $urandom_range(0, 2) != 0)) begin
          mem_gnt = 1; gw = mem_we; ga = mem_addr; gd = mem_wdata;
        end else if (!mem_req && !fast_mode && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1;
        end
      end
    end
  end

  // Copy datapath: stalls cmd_ready, checks the held command, pulses cmd_done later
  initial begin
    logic [64:0] cap;
    int stall_left, dwait;
    bit seen, pend;
    cap = '0; stall_left = 0; dwait = 0; seen = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cmd_ready = 0; cmd_done = 0; seen = 0; pend = 0;
      end else begin
        if (cmd_ready) begin
          act_cmd.push_back(cap);
          pend = 1; seen = 0;
          dwait = (fast_mode ? 0 : $urandom_range(0, 3)) + (long_done ? 30 : 0);
        end
        cmd_ready = 0;
        cmd_done = 0;
        if (pend) begin
          if (dwait == 0) begin cmd_done = 1; pend = 0; end
          else dwait--;
        end else if (cmd_valid) begin
          if (!seen) begin
            seen = 1;
            cap = {cmd_burst, cmd_src, cmd_dst};
            stall_left = stall_mode ? 3 : (fast_mode ? 0 : $urandom_range(0, 2));
          end else begin
            chk("cmd_hold", {cmd_burst, cmd_src, cmd_dst}, cap);
          end
          if (stall_left == 0) begin
            cmd_ready = 1;
            if (!fast_mode && $urandom_range(0, 3) == 0) cmd_done = 1;
          end else stall_left--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (irq === 1'b1) irq_cnt++;
    end
  end

  task automatic clear_obs();
    act_cmd.delete(); act_rd.delete(); act_wa.delete(); act_wd.delete();
    irq_cnt = 0;
  endtask

  task automatic run_task(input logic [31:0] tp, input logic [31:0] sp, input bit fast,
                          input bit stall, input bit extra, output int lat);
    int cyc;
    model(tp);
    clear_obs();
    fast_mode = fast;
    stall_mode = stall;
    @(negedge clk);
    task_pointer = tp; status_pointer = sp; start = 1;
    @(negedge clk);
    start = 0;
    task_pointer = $urandom; status_pointer = $urandom;
    chk("busy_after_start", busy, 1);
    cyc = 1;
    while (irq !== 1'b1 && cyc < 3000) begin
      if (extra && cyc == 4) begin start = 1; task_pointer = 32'h40; end
      else start = 0;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    lat = cyc;
    if (irq !== 1'b1) chk("irq_timeout", irq, 1);
    if (extra) begin
      start = 1; task_pointer = 32'h40;
      @(negedge clk);
      start = 0;
      chk("start_in_done_ignored", busy, 0);
    end
    repeat (3) @(negedge clk);
    chk("irq_count", 65'(irq_cnt), 65'd1);
    chk("cmd_count", 65'(act_cmd.size()), 65'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size() && i < act_cmd.size(); i++)
      chk($sformatf("cmd%0d", i), act_cmd[i], exp_cmd[i]);
    chk("read_count", 65'(act_rd.size()), 65'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk($sformatf("read_addr%0d", i), 65'(act_rd[i]), 65'(exp_rd[i]));
    chk("status_writes", 65'(act_wa.size()), 65'd1);
    if (act_wa.size() > 0) begin
      chk("status_addr", 65'(act_wa[0]), 65'(sp));
      chk("status_word", 65'(act_wd[0]), 65'({61'b0, exp_status}));
    end
    fast_mode = 0;
    stall_mode = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] tp, sp, t, u, l;
    reset = 1; start = 0; task_pointer = '0; status_pointer = '0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, irq, mem_req, mem_we, cmd_valid, cmd_burst}, 65'd0);
    chk("rst_mem_addr", 65'(mem_addr), 65'd0);
    chk("rst_mem_wdata", 65'(mem_wdata), 65'd0);
    chk("rst_cmd_addr", 65'({cmd_src, cmd_dst}), 65'd0);
    reset = 0;
    @(negedge clk);

    put_desc(32'h00, 0, 32'h00, 32'h08, 8);
    run_task(32'h00, 32'hF8, 1, 0, 0, lat);
    chk("min_latency", 65'(lat), 65'd9);

    put_desc(32'h00, 0, 32'h10, 32'h80, 24);
    run_task(32'h00, 32'hF0, 0, 0, 1, lat);
    put_desc(32'h40, 1, 32'h00, 32'h40, 64);
    run_task(32'h40, 32'hE8, 0, 1, 0, lat);
    put_desc(32'h00, 2, 32'h00, 32'h80, 32);
    put_desc(32'h20, 0, 32'h40, 32'hA0, 16);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);
    put_desc(32'h00, 0, 32'hF8, 32'h00, 16);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);
    put_desc(32'h00, 0, 32'h00, 32'h40, 12);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);
    put_desc(32'h00, 5, 32'h00, 32'h40, 8);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);
    put_desc(32'h00, 2, 32'h00, 32'h80, 32);
    put_desc(32'h20, 2, 32'h20, 32'hA0, 32);
    put_desc(32'h40, 2, 32'h40, 32'hC0, 32);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);

    // Reset while waiting for cmd_done
    put_desc(32'h00, 0, 32'h00, 32'h80, 64);
    clear_obs();
    long_done = 1;
    @(negedge clk);
    task_pointer = 32'h00; status_pointer = 32'hF0; start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 200 && act_cmd.size() == 0; c++) @(negedge clk);
    chk("rst_cmd_seen", 65'(act_cmd.size()), 65'd1);
    chk("rst_busy_before", busy, 1);
    #2 reset = 1;
    #1;
    chk("rst_async_drop", {busy, mem_req, cmd_valid}, 65'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    long_done = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_irq", 65'(irq_cnt), 65'd0);
    chk("rst_no_status", 65'(act_wa.size()), 65'd0);

    // Reset while a read request is waiting for grant
    gnt_hold = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20 && mem_req !== 1'b1; c++) @(negedge clk);
    chk("req_pending", mem_req, 1);
    #2 reset = 1;
    #1;
    chk("rst_req_drop", mem_req, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    gnt_hold = 0;
    @(negedge clk);
    put_desc(32'h00, 0, 32'h10, 32'h80, 24);
    run_task(32'h00, 32'hF0, 0, 0, 0, lat);

    for (int it = 0; it < 12; it++) begin
      tp = 32'($urandom_range(0, 2)) * 32'd32;
      for (int k = 0; k < 3; k++) begin
        t = ($urandom_range(0, 9) == 0) ? 32'd5 : 32'($urandom_range(0, 2));
        u = (t == 0) ? 32'd8 : 32'd32;
        l = 32'($urandom_range(0, 2)) * u;
        if ($urandom_range(0, 7) == 0) l = l + 32'd4;
        put_desc(tp + 32'(k) * 32'd32, t, 32'($urandom_range(0, 31)) * 32'd8,
                 32'($urandom_range(0, 31)) * 32'd8, l);
      end
      sp = 32'($urandom_range(20, 31)) * 32'd8;
      run_task(tp, sp, 0, (it % 4) == 1, (it % 3) == 0, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
